jt12_amp_ctrl: RTL and testbench

Volume sequencer for the stereo output amplifier stage.
- Takes a CPU-written target gain code and a mute request, then moves the amplifier's 3-bit volume code toward the target one step at a time, paced in sample periods.
- Each step is applied at a signal zero crossing, or at a timeout, so gain changes do not click.
- Sits between the register interface and the stereo amplifier; drives the amplifier's volume input and observes the same 14-bit pre-amplifier samples.

---
 rtl/jt12_amp_ctrl_pkg.sv | 22 ++
 rtl/jt12_amp_zc.sv | 37 +++
 rtl/jt12_amp_ctrl.sv | 137 +++++++++++++
 tb/tb_jt12_amp_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_amp_ctrl_pkg.sv
// Shared definitions for the amplifier volume sequencer: FSM state codes,
// volume code range and the counter sizing helper.
package jt12_amp_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_ZC   = 2'd2;

    localparam logic [2:0] VOL_MIN = 3'd0;
    localparam logic [2:0] VOL_MAX = 3'd7;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt12_amp_zc.sv
// Per-channel zero-crossing tracker: remembers the sign of the last sample and
// keeps a sticky flag of crossings seen while armed.
module jt12_amp_zc
    import jt12_amp_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_i,
    input  logic               clr_i,
    input  logic               arm_i,
    input  logic signed [13:0] din_i,
    output logic               cross_o
);

    logic sign_q;
    logic flag_q;
    logic cur_cross;

    // An exact zero counts as a crossing even without a sign change.
    assign cur_cross = (din_i[13] != sign_q) || (din_i == '0);
    assign cross_o   = flag_q | cur_cross;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            if (sample_i) sign_q <= din_i[13];
            if (clr_i) begin
                flag_q <= 1'b0;
            end else if (sample_i && arm_i && cur_cross) begin
                flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt12_amp_ctrl.sv
// Volume sequencer: walks the amplifier gain code one step at a time toward the
// effective target, spacing steps in samples and landing them on zero crossings.
module jt12_amp_ctrl
    import jt12_amp_ctrl_pkg::*;
#(
    parameter int RAMP_SAMPLES = 64,
    parameter int ZC_TIMEOUT   = 256
) (
    input  logic               rst_n,
    input  logic               clk,
    input  logic               sample,
    input  logic               vol_we,
    input  logic [2:0]         vol_din,
    input  logic               mute,
    input  logic signed [13:0] preleft,
    input  logic signed [13:0] preright,
    output logic [2:0]         volume,
    output logic               busy,
    output logic               step_forced
);

    localparam int GW = clog2(RAMP_SAMPLES);
    localparam int TW = clog2(ZC_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(RAMP_SAMPLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ZC_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    vol_q, vol_d;
    logic [2:0]    target_q, target_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic          busy_q;
    logic          forced_q, forced_d;
    logic [2:0]    eff;
    logic          cross_l, cross_r, both_cross;
    logic          zc_clr, zc_arm;

    assign eff        = mute ? VOL_MIN : target_q;
    assign both_cross = cross_l & cross_r;
    assign zc_arm     = (state_q == ST_ZC);

    jt12_amp_zc u_zc_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample),
        .clr_i    (zc_clr),
        .arm_i    (zc_arm),
        .din_i    (preleft),
        .cross_o  (cross_l)
    );

    jt12_amp_zc u_zc_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample),
        .clr_i    (zc_clr),
        .arm_i    (zc_arm),
        .din_i    (preright),
        .cross_o  (cross_r)
    );

    always_comb begin
        state_d  = state_q;
        vol_d    = vol_q;
        gap_d    = gap_q;
        to_d     = to_q;
        forced_d = 1'b0;
        zc_clr   = 1'b0;
        target_d = vol_we ? vol_din : target_q;
        case (state_q)
            ST_IDLE: begin
                if (vol_q != eff) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (vol_q == eff) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_ZC;
                        zc_clr  = 1'b1;
                        to_d    = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            ST_ZC: begin
                if (vol_q == eff) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    if (both_cross || (to_q == TO_LAST)) begin
                        // Step uses the eff seen this edge; a same-edge write lands next cycle.
                        if ((eff > vol_q) && (vol_q != VOL_MAX)) begin
                            vol_d = vol_q + 3'd1;
                        end else if ((eff < vol_q) && (vol_q != VOL_MIN)) begin
                            vol_d = vol_q - 3'd1;
                        end
                        forced_d = ~both_cross;
                        gap_d    = '0;
                        state_d  = (vol_d == eff) ? ST_IDLE : ST_GAP;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vol_q    <= VOL_MIN;
            target_q <= VOL_MIN;
            gap_q    <= '0;
            to_q     <= '0;
            busy_q   <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vol_q    <= vol_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
            busy_q   <= (vol_q != eff);
            forced_q <= forced_d;
        end
    end

    assign volume      = vol_q;
    assign busy        = busy_q;
    assign step_forced = forced_q;

endmodule

// File: tb/tb_jt12_amp_ctrl.sv
// Bench for jt12_amp_ctrl with short ramp/timeout: directed scenarios plus a
// randomized run, all compared against a sample-counting behavioural model.
module tb_jt12_amp_ctrl;

    localparam int RAMP = 4;
    localparam int TO   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample = 1'b0;
    logic               vol_we = 1'b0;
    logic [2:0]         vol_din = 3'd0;
    logic               mute = 1'b0;
    logic signed [13:0] preleft = '0;
    logic signed [13:0] preright = '0;
    logic [2:0]         volume;
    logic               busy;
    logic               step_forced;

    int vectors = 0;
    int miscompares = 0;

    jt12_amp_ctrl #(.RAMP_SAMPLES(RAMP), .ZC_TIMEOUT(TO)) dut (
        .rst_n       (rst_n),
        .clk         (clk),
        .sample      (sample),
        .vol_we      (vol_we),
        .vol_din     (vol_din),
        .mute        (mute),
        .preleft     (preleft),
        .preright    (preright),
        .volume      (volume),
        .busy        (busy),
        .step_forced (step_forced)
    );

    always #5 clk = ~clk;

    // Reference model: a single "samples since waiting began" count; the first
    // RAMP samples are the gap, the following ones the crossing window.
    logic [2:0]  m_vol = 3'd0, m_tgt = 3'd0, m_eff;
    logic        m_busy = 1'b0, m_forced = 1'b0, m_wait = 1'b0;
    logic        m_hL = 1'b0, m_hR = 1'b0, m_cl, m_cr, m_both;
    int          m_n = 0;
    logic [13:0] m_pL = '0, m_pR = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vol = 0; m_tgt = 0; m_busy = 0; m_forced = 0; m_wait = 0;
            m_n = 0; m_hL = 0; m_hR = 0; m_pL = '0; m_pR = '0;
        end else begin
            m_eff    = mute ? 3'd0 : m_tgt;
            m_busy   = (m_vol != m_eff);
            m_forced = 1'b0;
            m_cl = (preleft[13] != m_pL[13]) || (preleft == 0);
            m_cr = (preright[13] != m_pR[13]) || (preright == 0);
            if (!m_wait) begin
                if (m_vol != m_eff) begin m_wait = 1; m_n = 0; end
            end else if (m_vol == m_eff) begin
                m_wait = 0;
            end else if (sample) begin
                if (m_n < RAMP) begin
                    m_n++;
                    if (m_n == RAMP) begin m_hL = 0; m_hR = 0; end
                end else begin
                    m_both = (m_hL | m_cl) & (m_hR | m_cr);
                    if (m_both || (m_n - RAMP == TO - 1)) begin
                        m_vol    = (m_eff > m_vol) ? m_vol + 3'd1 : m_vol - 3'd1;
                        m_forced = !m_both;
                        m_wait   = (m_vol != m_eff);
                        m_n      = 0;
                    end else begin
                        m_hL = m_hL | m_cl;
                        m_hR = m_hR | m_cr;
                        m_n++;
                    end
                end
            end
            if (sample) begin m_pL = preleft; m_pR = preright; end
            if (vol_we) m_tgt = vol_din;
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
        sample = 1'b0;
        vol_we = 1'b0;
    endtask

    // One sample period: an idle cycle followed by the strobe cycle.
    task automatic smp();
        sample = 1'b0;
        step_clk();
        sample = 1'b1;
        step_clk();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (volume !== 3'd0) begin miscompares++; $display("FAIL reset_volume: got %0d want 0", volume); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (step_forced !== 1'b0) begin miscompares++; $display("FAIL reset_step_forced: got %0b want 0", step_forced); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_crossing();
        int last = 0, forced_n = 0;
        logic [2:0] prev;
        logic signed [13:0] v;
        vol_din = 3'd3; vol_we = 1'b1;
        step_clk();
        prev = volume;
        for (int k = 1; k <= 40 && volume != 3'd3; k++) begin
            v = (k % 2) ? 14'sd100 : -14'sd100;
            preleft = v; preright = -v;
            smp();
            vectors++;
            if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
                miscompares++;
                $display("FAIL model_ramp k=%0d: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", k, volume, busy, step_forced, m_vol, m_busy, m_forced);
            end
            if (step_forced) forced_n++;
            if (volume != prev) begin
                vectors++;
                if (volume != prev + 3'd1 || k - last < 4 || k - last > 5) begin
                    miscompares++;
                    $display("FAIL ramp_step: got vol=%0d after %0d samples, want vol=%0d after 4..5", volume, k - last, prev + 3'd1);
                end
                last = k; prev = volume;
            end
        end
        vectors++; if (volume !== 3'd3) begin miscompares++; $display("FAIL ramp_final: got %0d want 3", volume); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ramp_busy_hold: got %0b want 1", busy); end
        step_clk();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ramp_busy_fall: got %0b want 0", busy); end
        vectors++; if (forced_n != 0) begin miscompares++; $display("FAIL ramp_no_forced: got %0d pulses want 0", forced_n); end
    endtask

    task automatic test_timeout();
        int last = 0, forced_n = 0;
        logic [2:0] prev;
        preleft = 14'sd500; preright = 14'sd500;
        repeat (2) smp();
        vol_din = 3'd5; vol_we = 1'b1;
        step_clk();
        prev = volume;
        for (int k = 1; k <= 40 && volume != 3'd5; k++) begin
            smp();
            vectors++;
            if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
                miscompares++;
                $display("FAIL model_timeout k=%0d: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", k, volume, busy, step_forced, m_vol, m_busy, m_forced);
            end
            if (step_forced) forced_n++;
            if (volume != prev) begin
                vectors++;
                if (volume != prev + 3'd1 || k - last != RAMP + TO || step_forced !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_step: got vol=%0d after %0d samples sf=%0b, want vol=%0d after %0d sf=1", volume, k - last, step_forced, prev + 3'd1, RAMP + TO);
                end
                last = k; prev = volume;
            end
        end
        vectors++; if (volume !== 3'd5) begin miscompares++; $display("FAIL timeout_final: got %0d want 5", volume); end
        vectors++; if (forced_n != 2) begin miscompares++; $display("FAIL timeout_pulses: got %0d want 2", forced_n); end
    endtask

    task automatic test_mute_reversal();
        logic [2:0] seq[$];
        logic [2:0] exp_seq[6] = '{3'd4, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [2:0] prev;
        logic signed [13:0] v;
        mute = 1'b1;
        prev = volume;
        for (int k = 1; k <= 100 && !(!mute && volume == 3'd5); k++) begin
            v = (k % 2) ? 14'sd100 : -14'sd100;
            preleft = v; preright = v;
            smp();
            vectors++;
            if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
                miscompares++;
                $display("FAIL model_mute k=%0d: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", k, volume, busy, step_forced, m_vol, m_busy, m_forced);
            end
            if (volume != prev) begin
                seq.push_back(volume);
                prev = volume;
                if (mute && volume == 3'd2) mute = 1'b0;
            end
        end
        vectors++;
        if (seq.size() != 6) begin miscompares++; $display("FAIL mute_seq_len: got %0d want 6", seq.size()); end
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            vectors++;
            if (seq[i] !== exp_seq[i]) begin miscompares++; $display("FAIL mute_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
        end
        mute = 1'b0;
    endtask

    task automatic test_staggered_cross();
        preleft = 14'sd200; preright = 14'sd200;
        repeat (2) smp();
        vol_din = 3'd6; vol_we = 1'b1;
        step_clk();
        repeat (RAMP) smp();
        vectors++; if (volume !== 3'd5) begin miscompares++; $display("FAIL stagger_gap: got %0d want 5", volume); end
        preleft = -14'sd200; preright = 14'sd200;
        smp();
        vectors++; if (volume !== 3'd5) begin miscompares++; $display("FAIL stagger_zc1: got %0d want 5", volume); end
        smp();
        vectors++; if (volume !== 3'd5) begin miscompares++; $display("FAIL stagger_zc2: got %0d want 5", volume); end
        preright = -14'sd200;
        smp();
        vectors++; if (volume !== 3'd6 || step_forced !== 1'b0) begin miscompares++; $display("FAIL stagger_zc3: got vol=%0d sf=%0b want vol=6 sf=0", volume, step_forced); end
        vectors++;
        if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
            miscompares++;
            $display("FAIL model_stagger: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", volume, busy, step_forced, m_vol, m_busy, m_forced);
        end
    endtask

    task automatic test_zero_sample();
        preleft = 14'sd300; preright = 14'sd300;
        repeat (2) smp();
        vol_din = 3'd7; vol_we = 1'b1;
        step_clk();
        repeat (RAMP) smp();
        vectors++; if (volume !== 3'd6) begin miscompares++; $display("FAIL zero_gap: got %0d want 6", volume); end
        preleft = 14'sd0; preright = -14'sd300;
        smp();
        vectors++; if (volume !== 3'd7 || step_forced !== 1'b0) begin miscompares++; $display("FAIL zero_step: got vol=%0d sf=%0b want vol=7 sf=0", volume, step_forced); end
        vectors++;
        if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
            miscompares++;
            $display("FAIL model_zero: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", volume, busy, step_forced, m_vol, m_busy, m_forced);
        end
    endtask

    task automatic test_async_reset();
        logic signed [13:0] v;
        vol_din = 3'd1; vol_we = 1'b1;
        step_clk();
        for (int k = 1; k <= 12; k++) begin
            v = (k % 2) ? 14'sd100 : -14'sd100;
            preleft = v; preright = v;
            smp();
        end
        vectors++;
        if (volume !== m_vol || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: got vol=%0d busy=%0b want vol=%0d busy=1", volume, busy, m_vol);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (volume !== 3'd0 || busy !== 1'b0 || step_forced !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_async: got vol=%0d busy=%0b sf=%0b want 0 0 0", volume, busy, step_forced);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            v = (k % 2) ? 14'sd100 : -14'sd100;
            preleft = v; preright = v;
            smp();
            vectors++;
            if (volume !== 3'd0 || busy !== 1'b0 || step_forced !== 1'b0) begin
                miscompares++;
                $display("FAIL areset_hold k=%0d: got vol=%0d busy=%0b sf=%0b want 0 0 0", k, volume, busy, step_forced);
            end
        end
    endtask

    task automatic test_random();
        bit quiet = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) quiet = ($urandom_range(0, 2) == 0);
            vol_we  = ($urandom_range(0, 39) == 0);
            vol_din = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            sample = ($urandom_range(0, 2) == 0);
            if (quiet) begin
                preleft  = 14'($urandom_range(1, 8000));
                preright = 14'($urandom_range(1, 8000));
            end else begin
                preleft  = ($urandom_range(0, 15) == 0) ? 14'sd0 : 14'($urandom_range(0, 16383));
                preright = ($urandom_range(0, 15) == 0) ? 14'sd0 : 14'($urandom_range(0, 16383));
            end
            step_clk();
            vectors++;
            if (volume !== m_vol || busy !== m_busy || step_forced !== m_forced) begin
                miscompares++;
                $display("FAIL model_random c=%0d: got vol=%0d busy=%0b sf=%0b want vol=%0d busy=%0b sf=%0b", c, volume, busy, step_forced, m_vol, m_busy, m_forced);
            end
        end
        mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_crossing();
        test_timeout();
        test_mute_reversal();
        test_staggered_cross();
        test_zero_sample();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
